// File: rtl/uart_rx_stream_if.sv
// Byte-stream handshake between uart_rx_stream (master) and its consumer (slave).
// The master drives the FIFO head byte and its valid flag; the slave drives ready.
interface uart_rx_stream_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/uart_rx_stream.sv
// Oversampling 8N1 UART receiver feeding a small head-registered byte FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_stream #(
    parameter int CLKS_PER_TICK = 27,
    parameter int OVERSAMPLE    = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_rx,
    input  logic             i_clr,
    uart_rx_stream_if.master bus,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic             o_overrun,
    output logic             o_parity_err
);
    localparam int TW = $clog2(CLKS_PER_TICK);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_TICK - 32'sd1);
    localparam logic [SW-1:0] SAMP_MAX = SW'(OVERSAMPLE - 32'sd1);
    localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 32'sd2 - 32'sd1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_BRK    = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
`endif

    logic [1:0]    sync_r;
    logic          rxs_s;
    logic [TW-1:0] tick_cnt_r;
    logic          tick_s;
    logic [SW-1:0] samp_cnt_r;
    logic          samp_pt_s;
    logic [2:0]    state_r, state_nxt_s;
    logic [7:0]    shift_r, shift_nxt_s;
    logic [2:0]    bit_idx_r, bit_idx_nxt_s;
    logic          start_s, push_s, frame_evt_s;
    logic          busy_r, frame_err_r, overrun_r;
    logic [AW:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [7:0]    data_r, head_nxt_s;
    logic          valid_r, full_s, pop_s, wr_en_s, overrun_evt_s;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_r, par_bad_nxt_s, par_evt_s, parity_err_r;
`endif

    assign rxs_s     = sync_r[1];
    assign tick_s    = (tick_cnt_r == TICK_MAX);
    assign samp_pt_s = tick_s && (samp_cnt_r == SAMP_MID);

    // Two-flop synchronizer for the asynchronous serial pin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], i_rx};
        end
    end

    // Oversample tick and per-bit sample counters, realigned to each start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_r <= {TW{1'b0}};
            samp_cnt_r <= {SW{1'b0}};
        end else if (start_s) begin
            tick_cnt_r <= {TW{1'b0}};
            samp_cnt_r <= {SW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
            samp_cnt_r <= (samp_cnt_r == SAMP_MAX) ? {SW{1'b0}} : samp_cnt_r + 1'b1;
        end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
        end
    end

    // Framing FSM next-state: leaves STOP at the mid-bit sample so one stop bit suffices
    always_comb begin
        state_nxt_s   = state_r;
        shift_nxt_s   = shift_r;
        bit_idx_nxt_s = bit_idx_r;
        start_s       = 1'b0;
        push_s        = 1'b0;
        frame_evt_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt_s = par_bad_r;
        par_evt_s     = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!rxs_s) begin
                    state_nxt_s = ST_START;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (samp_pt_s) begin
                    if (!rxs_s) begin
                        state_nxt_s   = ST_DATA;
                        bit_idx_nxt_s = 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_bad_nxt_s = 1'b0;
`endif
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (samp_pt_s) begin
                    shift_nxt_s = {rxs_s, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = ST_PARITY;
`else
                        state_nxt_s = ST_STOP;
`endif
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (samp_pt_s) begin
                    if (rxs_s != (^shift_r)) begin
                        par_evt_s     = 1'b1;
                        par_bad_nxt_s = 1'b1;
                    end else begin
                        par_bad_nxt_s = 1'b0;
                    end
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (samp_pt_s) begin
                    if (rxs_s) begin
`ifdef UART_RX_PARITY_EN
                        push_s = ~par_bad_r;
`else
                        push_s = 1'b1;
`endif
                        state_nxt_s = ST_IDLE;
                    end else begin
                        frame_evt_s = 1'b1;
                        state_nxt_s = ST_BRK;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_BRK: begin
                if (rxs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BRK;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, shifter and sticky error flags (a new event outranks i_clr)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            shift_r     <= 8'h00;
            bit_idx_r   <= 3'd0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            shift_r     <= shift_nxt_s;
            bit_idx_r   <= bit_idx_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            frame_err_r <= frame_evt_s | (frame_err_r & ~i_clr);
            overrun_r   <= overrun_evt_s | (overrun_r & ~i_clr);
`ifdef UART_RX_PARITY_EN
            par_bad_r    <= par_bad_nxt_s;
            parity_err_r <= par_evt_s | (parity_err_r & ~i_clr);
`endif
        end
    end

    // FIFO pointer arithmetic; a push into a full FIFO only lands when a pop frees a slot
    always_comb begin
        pop_s         = valid_r & bus.i_ready;
        full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        wr_en_s       = push_s & (~full_s | pop_s);
        overrun_evt_s = push_s & full_s & ~pop_s;
        wr_ptr_nxt_s  = wr_en_s ? wr_ptr_r + 1'b1 : wr_ptr_r;
        rd_ptr_nxt_s  = pop_s ? rd_ptr_r + 1'b1 : rd_ptr_r;
        if (wr_en_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = shift_r;
        end else if (rd_ptr_nxt_s != wr_ptr_nxt_s) begin
            head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
        end else begin
            head_nxt_s = data_r;
        end
    end

    // FIFO storage, pointers and registered head/valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            valid_r  <= 1'b0;
            data_r   <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            valid_r  <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
            data_r   <= head_nxt_s;
            if (wr_en_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
            end
        end
    end

    assign bus.o_data  = data_r;
    assign bus.o_valid = valid_r;
    assign o_busy      = busy_r;
    assign o_frame_err = frame_err_r;
    assign o_overrun   = overrun_r;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_r;
`else
    assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: serial frames are driven on i_rx, expected bytes
// are queued as they are sent and compared when the consumer handshake pops them.
module tb_uart_rx_stream;
    localparam int CPT      = 4;
    localparam int OS       = 16;
    localparam int DEPTH    = 4;
    localparam int BIT_CLKS = CPT * OS;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Clocks from driving the start edge (at a falling clk edge) to the edge that registers the stop sample
    localparam int STOP_LAT = 3 + CPT * (OS / 2) + (NBITS - 1) * BIT_CLKS;

    logic clk = 1'b0;
    logic rst, rx, clr, busy, frame_err, overrun, parity_err;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    uart_rx_stream_if bus();

    uart_rx_stream #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .i_rx(rx), .i_clr(clr), .bus(bus),
        .o_busy(busy), .o_frame_err(frame_err), .o_overrun(overrun), .o_parity_err(parity_err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary within the time limit");
        $fatal(1, "timeout");
    end

    // Scoreboard: every accepted handshake must match the oldest queued byte
    always begin
        @(negedge clk);
        #2;
        if (rst && bus.o_valid && bus.i_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %02h expected no byte", bus.o_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (bus.o_data !== exp_b) begin
                    n_fail++;
                    $display("FAIL pop_data: got %02h expected %02h", bus.o_data, exp_b);
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic drain();
        bus.i_ready = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        bus.i_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; rx = 1'b1; clr = 1'b0; bus.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        n_checks++; if (bus.o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h expected 00", bus.o_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {frame_err, overrun, parity_err}); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_first_byte();
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (STOP_LAT - 1) @(negedge clk);
                n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: valid got %b expected 0", bus.o_valid); end
                @(negedge clk);
                n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b expected 1", bus.o_valid); end
                n_checks++; if (bus.o_data !== 8'hA5) begin n_fail++; $display("FAIL first_data: got %02h expected a5", bus.o_data); end
            end
        join
        drain();
        n_checks++; if (bus.o_valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL first_drain: valid %b left %0d expected 0 0", bus.o_valid, exp_q.size()); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b expected 1", busy); end
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS - 12) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: busy got %b expected 0", busy); end
        n_checks++; if (bus.o_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_nopush: valid %b frame_err %b expected 0 0", bus.o_valid, frame_err); end
    endtask

    task automatic test_overrun();
        logic [7:0] bytes [5];
        bytes = '{8'h01, 8'h03, 8'h04, 8'h7F, 8'h55};
        for (int i = 0; i < 4; i++) exp_q.push_back(bytes[i]);
        for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b1);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
        n_checks++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h01) begin n_fail++; $display("FAIL overrun_head: valid %b data %02h expected 1 01", bus.o_valid, bus.o_data); end
        drain();
        n_checks++; if (bus.o_valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL overrun_drain: valid %b left %0d expected 0 0", bus.o_valid, exp_q.size()); end
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clr: got %b expected 0", overrun); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
        for (int i = 0; i < 5; i++) exp_q.push_back(bytes[i]);
        for (int i = 0; i < 4; i++) send_frame(bytes[i], 1'b1);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (STOP_LAT - 1) @(negedge clk);
                bus.i_ready = 1'b1;
                @(negedge clk);
                bus.i_ready = 1'b0;
            end
        join
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL pushpop_overrun: got %b expected 0", overrun); end
        n_checks++; if (exp_q.size() != 4) begin n_fail++; $display("FAIL pushpop_popped: queue left %0d expected 4", exp_q.size()); end
        drain();
        n_checks++; if (bus.o_valid !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL pushpop_drain: valid %b left %0d expected 0 0", bus.o_valid, exp_q.size()); end
    endtask

    task automatic test_reset_mid_char();
        rx = 1'b0;
        repeat (200) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_checks++; if (bus.o_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_abandon: valid %b busy %b frame_err %b expected 0 0 0", bus.o_valid, busy, frame_err); end
    endtask

    task automatic test_frame_err();
        fork
            send_frame(8'h3C, 1'b0);
            begin
                repeat (STOP_LAT - 1) @(negedge clk);
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
            end
        join
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_set_with_clr: got %b expected 1", frame_err); end
        n_checks++; if (bus.o_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL frame_nopush: valid %b busy %b expected 0 1", bus.o_valid, busy); end
        repeat (40 * BIT_CLKS) @(negedge clk);
        n_checks++; if (bus.o_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL break_hold: valid %b busy %b expected 0 1", bus.o_valid, busy); end
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_release: busy got %b expected 0", busy); end
        exp_q.push_back(8'h02);
        send_frame(8'h02, 1'b1);
        n_checks++; if (bus.o_valid !== 1'b1 || frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_sticky: valid %b frame_err %b expected 1 1", bus.o_valid, frame_err); end
        drain();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL frame_after_byte: queue left %0d expected 0", exp_q.size()); end
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL frame_clr: got %b expected 0", frame_err); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        n_checks++; if (parity_err !== 1'b0 || bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL parity_good: err %b valid %b expected 0 1", parity_err, bus.o_valid); end
        drain();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        n_checks++; if (parity_err !== 1'b1 || bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL parity_bad: err %b valid %b expected 1 0", parity_err, bus.o_valid); end
        clr = 1'b1; @(negedge clk); clr = 1'b0;
        n_checks++; if (parity_err !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL parity_clr: err %b left %0d expected 0 0", parity_err, exp_q.size()); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_first_byte();
        test_glitch();
        test_overrun();
        test_full_push_pop();
        test_reset_mid_char();
        test_frame_err();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
